// File: rtl/flow_monitor_pkg.sv
// Shared types and helpers for the flow_monitor block and its thermometer decoder.
package flow_monitor_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_TRACK,
    ST_FAULT
  } state_e;

  function automatic int unsigned lvl_w(input int unsigned levels);
    return $clog2(levels + 1);
  endfunction

endpackage

// File: rtl/therm_decoder.sv
// Combinational thermometer-code checker: code_ok when ones are contiguous from bit 0,
// count = number of ones (the level).
module therm_decoder
  import flow_monitor_pkg::*;
#(
  parameter int unsigned LEVELS = 5
) (
  input  logic [LEVELS-1:0]         therm,
  output logic                      code_ok,
  output logic [lvl_w(LEVELS)-1:0]  count
);

  localparam int unsigned LW = lvl_w(LEVELS);

  always_comb begin
    code_ok = 1'b1;
    count   = '0;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      if (therm[i]) count = count + LW'(1);
    end
    // any one sitting above a zero breaks the thermometer pattern
    for (int unsigned i = 1; i < LEVELS; i++) begin
      if (therm[i] && !therm[i-1]) code_ok = 1'b0;
    end
  end

endmodule

// File: rtl/flow_monitor.sv
// Clocked flow monitor: persistence-filtered level commit, window flag Z, sticky fault Y.
// Define FLOW_MONITOR_HYST_EN to give Z one level of hysteresis around the window.
module flow_monitor
  import flow_monitor_pkg::*;
#(
  parameter int unsigned LEVELS   = 5,
  parameter int unsigned LO_LEVEL = 2,
  parameter int unsigned HI_LEVEL = 5,
  parameter int unsigned PERSIST  = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  input  logic [LEVELS-1:0]          therm,
  input  logic                       clear,
  output logic [lvl_w(LEVELS)-1:0]   level,
  output logic                       level_valid,
  output logic                       Z,
  output logic                       Y,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int unsigned LW = lvl_w(LEVELS);
  localparam int unsigned PW = $clog2(PERSIST + 1);
`ifdef FLOW_MONITOR_HYST_EN
  localparam int unsigned LO_HOLD = (LO_LEVEL == 0) ? 0 : LO_LEVEL - 1;
  localparam int unsigned HI_HOLD = (HI_LEVEL >= LEVELS) ? LEVELS : HI_LEVEL + 1;
`endif

  state_e           r_state, w_state;
  logic [LW-1:0]    r_level, w_level;
  logic [LW-1:0]    r_cand,  w_cand;
  logic [PW-1:0]    r_pcnt,  w_pcnt;
  logic             r_lv,    w_lv;
  logic             r_z,     w_z;
  logic             r_y,     w_y;
  logic [ERR_W-1:0] r_err,   w_err;

  logic             w_code_ok;
  logic [LW-1:0]    w_count;
  logic             w_in_win;
  logic             w_hold;

  therm_decoder #(.LEVELS(LEVELS)) u_dec (
    .therm   (therm),
    .code_ok (w_code_ok),
    .count   (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_level <= '0;
      r_cand  <= '0;
      r_pcnt  <= '0;
      r_lv    <= 1'b0;
      r_z     <= 1'b0;
      r_y     <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state;
      r_level <= w_level;
      r_cand  <= w_cand;
      r_pcnt  <= w_pcnt;
      r_lv    <= w_lv;
      r_z     <= w_z;
      r_y     <= w_y;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_level  = r_level;
    w_cand   = r_cand;
    w_pcnt   = r_pcnt;
    w_lv     = r_lv;
    w_z      = r_z;
    w_y      = r_y;
    w_err    = r_err;
    w_in_win = 1'b0;
    w_hold   = 1'b0;

    if (clear) begin
      w_err = '0;
      if (r_state == ST_FAULT) begin
        w_state = ST_INIT;
        w_y     = 1'b0;
      end
    end else if (sample_valid) begin
      if (!w_code_ok) begin
        w_state = ST_FAULT;
        w_y     = 1'b1;
        w_lv    = 1'b0;
        w_z     = 1'b0;
        w_cand  = '0;
        w_pcnt  = '0;
        if (r_err != '1) w_err = r_err + ERR_W'(1);
      end else if (r_state != ST_FAULT) begin
        if (w_count == r_cand) begin
          if (r_pcnt != PW'(PERSIST)) w_pcnt = r_pcnt + PW'(1);
        end else begin
          w_cand = w_count;
          w_pcnt = PW'(1);
        end
        if (w_pcnt == PW'(PERSIST)) begin
          w_level  = w_cand;
          w_state  = ST_TRACK;
          w_lv     = 1'b1;
          w_in_win = (32'(w_cand) >= LO_LEVEL) && (32'(w_cand) <= HI_LEVEL);
`ifdef FLOW_MONITOR_HYST_EN
          // r_z is only ever 1 while already tracking, so entry from INIT needs the window
          w_hold   = (32'(w_cand) >= LO_HOLD) && (32'(w_cand) <= HI_HOLD);
          w_z      = w_in_win | (r_z & w_hold);
`else
          w_z      = w_in_win;
`endif
        end
      end
    end
  end

  assign level       = r_level;
  assign level_valid = r_lv;
  assign Z           = r_z;
  assign Y           = r_y;
  assign err_cnt     = r_err;

endmodule

// File: tb/tb_flow_monitor.sv
// Scoreboard bench for flow_monitor: directed scenarios plus random samples,
// expected outputs from a behavioural model queued per cycle and checked by a monitor.
module tb_flow_monitor;

  localparam int LEVELS   = 5;
  localparam int LO_LEVEL = 2;
  localparam int HI_LEVEL = 5;
  localparam int PERSIST  = 4;
  localparam int ERR_W    = 8;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  typedef struct {
    int level;
    bit lv;
    bit z;
    bit y;
    int err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_valid = 1'b0;
  logic [LEVELS-1:0] therm = '0;
  logic             clear = 1'b0;
  logic [2:0]       level;
  logic             level_valid;
  logic             Z;
  logic             Y;
  logic [ERR_W-1:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];

  // model state
  bit m_committed, m_fault, m_z;
  int m_level, m_cand, m_run, m_err;

  flow_monitor #(
    .LEVELS   (LEVELS),
    .LO_LEVEL (LO_LEVEL),
    .HI_LEVEL (HI_LEVEL),
    .PERSIST  (PERSIST),
    .ERR_W    (ERR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .therm        (therm),
    .clear        (clear),
    .level        (level),
    .level_valid  (level_valid),
    .Z            (Z),
    .Y            (Y),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t cur_exp();
    exp_t e;
    e.level = m_level;
    e.lv    = m_committed;
    e.z     = m_z;
    e.y     = m_fault;
    e.err   = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_committed = 0; m_fault = 0; m_z = 0;
    m_level = 0; m_cand = 0; m_run = 0; m_err = 0;
  endtask

  task automatic model_step(input bit sv, input logic [LEVELS-1:0] th, input bit clr);
    bit ok;
    int val;
    ok = 0; val = 0;
    for (int n = 0; n <= LEVELS; n++)
      if (int'(th) == (1 << n) - 1) begin ok = 1; val = n; end
    if (clr) begin
      m_err = 0;
      if (m_fault) begin m_fault = 0; m_committed = 0; end
    end else if (sv) begin
      if (!ok) begin
        m_fault = 1; m_committed = 0; m_z = 0; m_cand = 0; m_run = 0;
        if (m_err < ERR_MAX) m_err++;
      end else if (!m_fault) begin
        if (val == m_cand) m_run++;
        else begin m_cand = val; m_run = 1; end
        if (m_run >= PERSIST) begin
          bit inside_win;
          m_level = m_cand;
          m_committed = 1;
          inside_win = (m_level >= LO_LEVEL) && (m_level <= HI_LEVEL);
`ifdef FLOW_MONITOR_HYST_EN
          if (inside_win) m_z = 1;
          else if (m_level < LO_LEVEL - 1 || m_level > HI_LEVEL + 1) m_z = 0;
`else
          m_z = inside_win;
`endif
        end
      end
    end
  endtask

  task automatic step(input bit sv, input logic [LEVELS-1:0] th, input bit clr);
    @(negedge clk);
    sample_valid = sv; therm = th; clear = clr;
    @(posedge clk);
    #1;
    model_step(sv, th, clr);
    q.push_back(cur_exp());
  endtask

  task automatic repeat_sample(input logic [LEVELS-1:0] th, input int n);
    for (int i = 0; i < n; i++) step(1'b1, th, 1'b0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    sample_valid = 1'b0; clear = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    q.push_back(cur_exp());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: compares one queued expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (int'(level) != e.level || level_valid !== e.lv || Z !== e.z ||
            Y !== e.y || int'(err_cnt) != e.err) begin
          n_fail++;
          $display("FAIL outputs t=%0t: got level=%0d lv=%0b Z=%0b Y=%0b err=%0d, want level=%0d lv=%0b Z=%0b Y=%0b err=%0d",
                   $time, level, level_valid, Z, Y, err_cnt, e.level, e.lv, e.z, e.y, e.err);
        end
      end
    end
  end

  initial begin
    int n, hold;
    logic [LEVELS-1:0] th;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, '0, 1'b0);                       // reset state
    repeat_sample(5'b00011, 4);                 // commit level 2
    repeat_sample(5'b00001, 4);                 // commit level 1
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'b00001, 1'b0);
      step(1'b1, 5'b00011, 1'b0);
    end
    step(1'b1, 5'b00101, 1'b0);                 // malformed from TRACK
    repeat_sample(5'b01010, 3);
    step(1'b1, 5'b00011, 1'b0);                 // valid sample ignored in FAULT
    step(1'b0, '0, 1'b1);                       // clear
    step(1'b1, 5'b10000, 1'b0);
    step(1'b1, 5'b10000, 1'b1);                 // clear with bad sample
    repeat_sample(5'b11111, 4);
    step(1'b0, '0, 1'b1);                       // clear while tracking
    repeat_sample(5'b00000, 4);
    repeat_sample(5'b00011, 4);                 // hysteresis walk 2 -> 1 -> 0
    repeat_sample(5'b00001, 4);
    repeat_sample(5'b00000, 4);
    repeat_sample(5'b00111, 2);
    mid_reset();                                // reset mid-persistence
    repeat_sample(5'b00111, 3);
    step(1'b0, '0, 1'b0);
    repeat_sample(5'b11011, 260);               // counter saturation
    step(1'b0, '0, 1'b1);
    repeat_sample(5'b01111, 5);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 11) == 0) th = LEVELS'($urandom_range(0, 31));
      else begin
        n  = $urandom_range(0, LEVELS);
        th = LEVELS'((1 << n) - 1);
      end
      hold = $urandom_range(1, 6);
      for (int j = 0; j < hold; j++)
        step($urandom_range(0, 5) != 0, th, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flow_monitor.md
# flow_monitor

Parametrised, clocked successor to the combinational flow-meter decoder. Accepts a thermometer-coded level-sensor word once per `sample_valid` and rejects malformed codes. Each level must persist for a programmable number of samples before it is committed. Drives a registered in-window flag `Z`, a sticky fault flag `Y` and the committed level to the pump-control logic.

## Interface
Parameters:
- `LEVELS`, 5: number of sensor taps (thermometer width); level range 0..LEVELS
- `LO_LEVEL`, 2: lowest level counted as in-window (inclusive)
- `HI_LEVEL`, 5: highest level counted as in-window (inclusive); requires LO_LEVEL <= HI_LEVEL <= LEVELS
- `PERSIST`, 4: consecutive identical valid samples needed to commit a level (>= 1)
- `ERR_W`, 8: width of the saturating fault counter

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `sample_valid`  in  1  `therm` is sampled this cycle
- `therm`  in  LEVELS  sensor word; bit 0 = lowest tap
- `clear`  in  1  one-cycle pulse; exits FAULT and zeroes `err_cnt`
- `level`  out  $clog2(LEVELS+1)  committed level
- `level_valid`  out  1  a level is committed
- `Z`  out  1  committed level inside the window
- `Y`  out  1  sticky malformed-code fault
- `err_cnt`  out  ERR_W  malformed samples seen; saturates at all-ones

## Operation
- Valid code: contiguous ones from bit 0, with zeros above. All-zeros (level 0) and all-ones (level LEVELS) are valid. Decoded level = count of ones.
- FSM states: INIT (nothing committed), TRACK (level committed), FAULT.
- Persistence:
  - Candidate register plus counter `pcnt`.
  - A valid sample equal to the candidate increments `pcnt`, saturating at PERSIST.
  - A valid sample that differs loads it as the new candidate and sets `pcnt` to 1.
  - When `pcnt` reaches PERSIST, `level` is loaded from the candidate and the FSM moves INIT->TRACK, or stays in TRACK.
  - With PERSIST = 1, every valid sample commits immediately.
- INIT: `level_valid`=0, `Z`=0.
- TRACK: `level_valid`=1. `Z` = (LO_LEVEL <= level <= HI_LEVEL). The committed level holds while a new candidate builds up.
- Malformed sample, in any state:
  - Go to FAULT.
  - `Y`=1, `level_valid`=0, `Z`=0.
  - Candidate and `pcnt` cleared.
  - `err_cnt` increments, saturating.
- FAULT:
  - Further samples are ignored for persistence.
  - Malformed samples still increment `err_cnt`.
  - Only `clear` leaves FAULT, going to INIT with `Y`=0 and `err_cnt`=0.
- `clear` in INIT or TRACK: zeroes `err_cnt` only; the FSM and committed level are kept.
- `clear` together with `sample_valid`: `clear` wins and the sample is discarded.
- Cycles without `sample_valid` change nothing.

## Timing
- All outputs are registered and take effect at the rising edge that samples the qualifying input; they are visible the following cycle.
- Commit latency: `level`/`level_valid`/`Z` update at the edge of the PERSIST-th consecutive identical valid sample.
- Fault latency: `Y`=1 and `Z`=0 at the same edge as the malformed sample, with no persistence delay.
- Reset values: FSM=INIT, `level`=0, `level_valid`=0, `Z`=0, `Y`=0, `err_cnt`=0, candidate=0, `pcnt`=0.
- Assertion of `rst_n` mid-run takes effect immediately and asynchronously. Deassertion is synchronous to `clk` through an external synchroniser.

## Configuration
- `FLOW_MONITOR_HYST_EN` defined: `Z` uses one level of hysteresis.
  - `Z` rises when level is in [LO_LEVEL, HI_LEVEL].
  - `Z` falls only when level < LO_LEVEL-1 or level > HI_LEVEL+1.
  - Bounds are clamped at 0 and LEVELS.
  - Leaving TRACK still forces `Z`=0.
- `FLOW_MONITOR_HYST_EN` undefined: plain window compare as in Operation.

## Structure
- Package `flow_monitor_pkg` holds:
  - the FSM state typedef (INIT, TRACK, FAULT);
  - the level-width function `lvl_w(LEVELS)`.
- Sub-module `therm_decoder`: purely combinational, parametrised by LEVELS. Outputs `code_ok` and `count`. It is reused by other sensor blocks.
- The top module holds the FSM, the persistence counter, the window/hysteresis logic and the error counter.

## Test plan
- Defaults, PERSIST=4. Four samples of 5'b00011 -> `level`=2, `level_valid`=1, `Z`=1 one cycle after the 4th sample. After 3 samples, `level_valid` is still 0.
- From TRACK at level 2, four samples of 5'b00001 -> `level`=1, `Z`=0. Samples alternating 00001/00011 never commit.
- Sample 5'b00101 while in TRACK -> `Y`=1, `Z`=0, `level_valid`=0, `err_cnt`=1 next cycle. Three more bad samples -> `err_cnt`=4. `clear` -> `Y`=0, `err_cnt`=0, state INIT.
- `clear` and a malformed sample in the same cycle while in FAULT -> INIT, `err_cnt`=0, sample ignored. With ERR_W=2 and 5 bad samples, `err_cnt` stays at 3.
- Full scale: 5'b11111 ×4 -> `level`=5, `Z`=1. 5'b00000 ×4 -> `level`=0, `Z`=0.
- With `FLOW_MONITOR_HYST_EN` and LO_LEVEL=2: committed level goes 2 -> 1, so `Z` stays 1; then 0, so `Z`=0. `rst_n` low mid-persistence clears everything.
